// File: rtl/serializador_matriz_pkg.sv
// -----------------------------------------------------------------------------
// serializador_matriz_pkg
// Definitions shared by the matrix serializer and the matrix arithmetic units:
//   - MATRIZ_5x5 range and INDICE(coluna,linha) macro for the flattened bus
//   - DIM, ELEM_W and the 200-bit matrix width
//   - state encoding of the serializer (OCIOSO=0, ENVIANDO=1)
//   - indice_plano(): flat element index of (coluna,linha)
// -----------------------------------------------------------------------------
`ifndef SERIALIZADOR_MATRIZ_DEFS
`define SERIALIZADOR_MATRIZ_DEFS
`define MATRIZ_5x5 199:0
`define INDICE(coluna, linha) ((linha) + 5 * (coluna))
`endif

package serializador_matriz_pkg;

  localparam int DIM      = 5;                    // only 5 is supported
  localparam int ELEM_W   = 8;                    // two's complement element
  localparam int MATRIZ_W = DIM * DIM * ELEM_W;   // 200-bit flattened matrix
  localparam int IDX_W    = 3;                    // holds 0..DIM-1
  localparam int FLAT_W   = 5;                    // holds 0..DIM*DIM-1
  localparam int BIT_W    = 8;                    // holds bit offsets 0..192

  typedef enum logic {
    OCIOSO   = 1'b0,
    ENVIANDO = 1'b1
  } estado_t;

  // Element (coluna,linha) lives at flat index linha + DIM*coluna.
  function automatic logic [FLAT_W-1:0] indice_plano(
    input logic [IDX_W-1:0] coluna,
    input logic [IDX_W-1:0] linha
  );
    return FLAT_W'(linha) + FLAT_W'(DIM) * FLAT_W'(coluna);
  endfunction

endpackage

// File: rtl/serializador_matriz_contador.sv
// -----------------------------------------------------------------------------
// contador_indice_matriz
// 2-D column/row counter walking a DIM x DIM matrix with linha as the inner
// loop and coluna as the outer loop.
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-high reset
//   habilitar       advance one position
//   limpar          return to (0,0); wins over habilitar
//   coluna, linha   current position
//   fim             high at the final position (DIM-1, DIM-1)
// -----------------------------------------------------------------------------
module contador_indice_matriz
  import serializador_matriz_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             habilitar,
  input  logic             limpar,
  output logic [IDX_W-1:0] coluna,
  output logic [IDX_W-1:0] linha,
  output logic             fim
);

  localparam logic [IDX_W-1:0] ULTIMO_IDX = IDX_W'(DIM - 1);

  logic [IDX_W-1:0] r_coluna;
  logic [IDX_W-1:0] r_linha;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_coluna <= '0;
      r_linha  <= '0;
    end else if (limpar) begin
      r_coluna <= '0;
      r_linha  <= '0;
    end else if (habilitar) begin
      if (r_linha == ULTIMO_IDX) begin
        r_linha  <= '0;
        r_coluna <= r_coluna + 1'b1;
      end else begin
        r_linha <= r_linha + 1'b1;
      end
    end
  end

  assign coluna = r_coluna;
  assign linha  = r_linha;
  assign fim    = (r_coluna == ULTIMO_IDX) && (r_linha == ULTIMO_IDX);

endmodule

// File: rtl/serializador_matriz.sv
// -----------------------------------------------------------------------------
// serializador_matriz
// Captures one flattened 5x5 signed 8-bit matrix through a valid/ready
// handshake and streams it out one element per beat, coluna outer loop,
// linha inner loop, with the indices and a last-element flag on every beat.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   matriz_entrada   flattened matrix, element (c,l) at [8*(l+5*c) +: 8]
//   entrada_valida   matriz_entrada is valid
//   entrada_pronta   block can accept a matrix (combinational from
//                    saida_pronta on the last beat for back-to-back capture)
//   cancelar         synchronous abort of the transfer in progress
//   elemento_saida   signed element of the current beat
//   coluna_saida     column index of the current beat
//   linha_saida      row index of the current beat
//   ultimo_saida     high on the (4,4) beat
//   saida_valida     beat valid
//   saida_pronta     downstream accepts the beat
// -----------------------------------------------------------------------------
module serializador_matriz
  import serializador_matriz_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic [MATRIZ_W-1:0]      matriz_entrada,
  input  logic                     entrada_valida,
  output logic                     entrada_pronta,
  input  logic                     cancelar,
  output logic signed [ELEM_W-1:0] elemento_saida,
  output logic [IDX_W-1:0]         coluna_saida,
  output logic [IDX_W-1:0]         linha_saida,
  output logic                     ultimo_saida,
  output logic                     saida_valida,
  input  logic                     saida_pronta
);

  estado_t             r_estado;
  estado_t             w_prox_estado;
  logic [MATRIZ_W-1:0] r_matriz;

  logic                w_captura;
  logic                w_limpar;
  logic                w_habilitar;
  logic                w_transfer;
  logic                w_fim;
  logic [IDX_W-1:0]    w_coluna;
  logic [IDX_W-1:0]    w_linha;
  logic [FLAT_W-1:0]   w_indice;
  logic [BIT_W-1:0]    w_base_bit;

  contador_indice_matriz u_contador (
    .clock     (clock),
    .reset     (reset),
    .habilitar (w_habilitar),
    .limpar    (w_limpar),
    .coluna    (w_coluna),
    .linha     (w_linha),
    .fim       (w_fim)
  );

  assign w_transfer = (r_estado == ENVIANDO) && saida_pronta;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_prox_estado = r_estado;
    w_captura     = 1'b0;
    w_limpar      = 1'b0;
    w_habilitar   = 1'b0;
    unique case (r_estado)
      OCIOSO: begin
        // cancelar is meaningless with nothing in flight
        if (entrada_valida) begin
          w_captura     = 1'b1;
          w_limpar      = 1'b1;
          w_prox_estado = ENVIANDO;
        end
      end
      ENVIANDO: begin
        if (cancelar) begin
          // abort beats both the pending beat and a back-to-back capture
          w_limpar      = 1'b1;
          w_prox_estado = OCIOSO;
        end else if (w_transfer) begin
          if (w_fim) begin
            w_limpar = 1'b1;
            if (entrada_valida) begin
              w_captura = 1'b1;      // zero-bubble start of the next matrix
            end else begin
              w_prox_estado = OCIOSO;
            end
          end else begin
            w_habilitar = 1'b1;
          end
        end
      end
      default: begin
        w_limpar      = 1'b1;
        w_prox_estado = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  // NOTE: the capture register is a wide data store, yet it is cleared on
  // reset because the element output must read 0 straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_matriz <= '0;
    end else if (w_captura) begin
      r_matriz <= matriz_entrada;
    end
  end

  assign w_indice   = indice_plano(w_coluna, w_linha);
  assign w_base_bit = BIT_W'(w_indice) * BIT_W'(ELEM_W);

  // ready is held low during reset even though the state already reads OCIOSO
  assign entrada_pronta = !reset &&
                          ((r_estado == OCIOSO) || (w_transfer && w_fim));

  assign saida_valida   = (r_estado == ENVIANDO);
  assign ultimo_saida   = (r_estado == ENVIANDO) && w_fim;
  assign elemento_saida = r_matriz[w_base_bit +: ELEM_W];
  assign coluna_saida   = w_coluna;
  assign linha_saida    = w_linha;

endmodule

// File: tb/tb_serializador_matriz.sv
// -----------------------------------------------------------------------------
// tb_serializador_matriz
// Drives serializador_matriz with directed and random traffic and compares
// every cycle against a queue of expected beats built from the matrix order
// (beat k = element k, coluna k/5, linha k%5, last when k==24).
// -----------------------------------------------------------------------------
module tb_serializador_matriz;
  import serializador_matriz_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic [MATRIZ_W-1:0] matriz_entrada;
  logic                entrada_valida;
  logic                entrada_pronta;
  logic                cancelar;
  logic [ELEM_W-1:0]   elemento_saida;
  logic [IDX_W-1:0]    coluna_saida;
  logic [IDX_W-1:0]    linha_saida;
  logic                ultimo_saida;
  logic                saida_valida;
  logic                saida_pronta;

  serializador_matriz dut (
    .clock          (clock),
    .reset          (reset),
    .matriz_entrada (matriz_entrada),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .cancelar       (cancelar),
    .elemento_saida (elemento_saida),
    .coluna_saida   (coluna_saida),
    .linha_saida    (linha_saida),
    .ultimo_saida   (ultimo_saida),
    .saida_valida   (saida_valida),
    .saida_pronta   (saida_pronta)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    int         k;
    logic [7:0] elem;
  } beat_t;

  beat_t fila[$];
  int    aceitas = 0;

  task automatic empilha(input logic [MATRIZ_W-1:0] m);
    for (int k = 0; k < DIM * DIM; k++) begin
      beat_t b;
      b.k    = k;
      b.elem = m[8*k +: 8];
      fila.push_back(b);
    end
    aceitas++;
  endtask

  function automatic logic [MATRIZ_W-1:0] matriz_rampa();
    logic [MATRIZ_W-1:0] m;
    for (int k = 0; k < DIM * DIM; k++) m[8*k +: 8] = 8'(k - 12);
    return m;
  endfunction

  function automatic logic [MATRIZ_W-1:0] matriz_const(input logic [7:0] v);
    logic [MATRIZ_W-1:0] m;
    for (int k = 0; k < DIM * DIM; k++) m[8*k +: 8] = v;
    return m;
  endfunction

  function automatic logic [MATRIZ_W-1:0] matriz_aleat();
    logic [MATRIZ_W-1:0] m;
    for (int k = 0; k < DIM * DIM; k++) m[8*k +: 8] = 8'($urandom);
    return m;
  endfunction

  // Called at negedge+1 after inputs are set: compares the visible beat and
  // ready, then applies what the coming rising edge does to the model.
  task automatic ciclo();
    logic ocupado;
    logic exp_pronta;
    #1;
    ocupado    = (fila.size() != 0);
    exp_pronta = !ocupado || (fila.size() == 1 && saida_pronta);
    check("saida_valida", 32'(saida_valida), 32'(ocupado));
    check("entrada_pronta", 32'(entrada_pronta), 32'(exp_pronta));
    if (ocupado) begin
      check("elemento", 32'(elemento_saida), 32'(fila[0].elem));
      check("coluna", 32'(coluna_saida), fila[0].k / 5);
      check("linha", 32'(linha_saida), fila[0].k % 5);
      check("ultimo", 32'(ultimo_saida), 32'(fila[0].k == 24));
    end
    if (ocupado && cancelar) begin
      fila.delete();
    end else begin
      if (ocupado && saida_pronta) void'(fila.pop_front());
      if (entrada_valida && exp_pronta) empilha(matriz_entrada);
    end
    @(negedge clock);
    #1;
  endtask

  task automatic avanca_ate(input int k);
    for (int i = 0; i < 80; i++) begin
      if (fila.size() != 0 && fila[0].k == k) return;
      ciclo();
    end
    check("timeout_beat", 32'(fila.size() != 0 && fila[0].k == k), 32'd1);
  endtask

  task automatic drena();
    for (int i = 0; i < 400; i++) begin
      if (fila.size() == 0) return;
      ciclo();
    end
    check("timeout_drena", fila.size(), 32'd0);
  endtask

  task automatic captura(input logic [MATRIZ_W-1:0] m);
    matriz_entrada = m;
    entrada_valida = 1'b1;
    ciclo();
    entrada_valida = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  int padrao[4] = '{1, 0, 0, 1};

  initial begin
    reset          = 1'b1;
    matriz_entrada = '0;
    entrada_valida = 1'b0;
    cancelar       = 1'b0;
    saida_pronta   = 1'b1;
    @(negedge clock);
    #1;
    // reset state
    check("rst_pronta", 32'(entrada_pronta), 32'd0);
    check("rst_valida", 32'(saida_valida), 32'd0);
    check("rst_ultimo", 32'(ultimo_saida), 32'd0);
    check("rst_elem", 32'(elemento_saida), 32'd0);
    check("rst_coluna", 32'(coluna_saida), 32'd0);
    check("rst_linha", 32'(linha_saida), 32'd0);
    reset = 1'b0;
    #1;
    check("pos_rst_pronta", 32'(entrada_pronta), 32'd1);
    @(negedge clock);
    #1;

    // 1) ramp matrix, continuous ready
    captura(matriz_rampa());
    matriz_entrada = '1;   // input may change freely after capture
    check("beat0_elem", 32'(elemento_saida), 32'h0000_00F4);
    drena();
    check("ocioso_apos_rampa", 32'(saida_valida), 32'd0);

    // 2) same matrix, ready pattern 1,0,0,1
    captura(matriz_rampa());
    for (int i = 0; i < 400 && fila.size() != 0; i++) begin
      saida_pronta = padrao[i % 4][0];
      ciclo();
    end
    check("fim_padrao", fila.size(), 32'd0);
    saida_pronta = 1'b1;
    ciclo();

    // 3) back-to-back 0x7F then 0x80 with valid held
    begin
      int base;
      base           = aceitas;
      matriz_entrada = matriz_const(8'h7F);
      entrada_valida = 1'b1;
      for (int i = 0; i < 120; i++) begin
        ciclo();
        if (aceitas == base + 1) matriz_entrada = matriz_const(8'h80);
        if (aceitas == base + 2) entrada_valida = 1'b0;
        if (fila.size() == 0 && aceitas == base + 2) break;
      end
      check("b2b_aceitas", aceitas - base, 32'd2);
      entrada_valida = 1'b0;
    end
    ciclo();

    // 4) cancel on beat 7 together with ready
    captura(matriz_aleat());
    avanca_ate(7);
    cancelar = 1'b1;
    ciclo();
    cancelar = 1'b0;
    check("pos_cancel_valida", 32'(saida_valida), 32'd0);
    ciclo();
    captura(matriz_aleat());
    check("nova_coluna", 32'(coluna_saida), 32'd0);
    check("nova_linha", 32'(linha_saida), 32'd0);
    drena();

    // 5) asynchronous reset during beat 13
    captura(matriz_aleat());
    avanca_ate(13);
    #2;
    reset          = 1'b1;
    entrada_valida = 1'b0;
    #1;
    check("rst_async_valida", 32'(saida_valida), 32'd0);
    check("rst_async_pronta", 32'(entrada_pronta), 32'd0);
    fila.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_async_pos_pronta", 32'(entrada_pronta), 32'd1);
    check("rst_async_elem", 32'(elemento_saida), 32'd0);
    repeat (5) ciclo();

    // 6) valid pulse mid-stream with different data is ignored
    captura(matriz_rampa());
    avanca_ate(10);
    matriz_entrada = matriz_const(8'h55);
    entrada_valida = 1'b1;
    ciclo();
    entrada_valida = 1'b0;
    drena();

    // 7) random traffic
    for (int i = 0; i < 3000; i++) begin
      matriz_entrada = matriz_aleat();
      entrada_valida = ($urandom_range(0, 3) == 0);
      saida_pronta   = ($urandom_range(0, 3) != 0);
      cancelar       = ($urandom_range(0, 60) == 0);
      ciclo();
    end
    entrada_valida = 1'b0;
    cancelar       = 1'b0;
    saida_pronta   = 1'b1;
    drena();
    ciclo();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
